dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Two-to-one arbiter sharing the single external DRAM port between the instruction-side and data-side L1 caches. Each cache drives its own DRAM-facing request bundle (addr, cs, we, write line, ack, read line), and the arbiter grants one line transfer at a time. It forwards the granted cache's request to DRAM and routes the DRAM acknowledge back to that cache only. It sits between the two L1 cache instances and the DRAM model in the CPU top level.

## Interface
- addr_width, 32, byte address width
- mem_data_width, 256, cache line width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_addr  in  addr_width  I-cache line address
- i_cs  in  1  I-cache request, held high until i_ack
- i_we  in  1  I-cache write (write-back) when 1
- i_wdata  in  mem_data_width  I-cache line to write
- i_ack  out  1  I-cache completion strobe
- i_rdata  out  mem_data_width  line read from DRAM
- d_addr, d_cs, d_we, d_wdata, d_ack, d_rdata: same as i_*, for the D-cache
- mem_addr  out  addr_width  to DRAM
- mem_cs  out  1  to DRAM
- mem_we  out  1  to DRAM
- mem_wdata  out  mem_data_width  to DRAM
- mem_ack  in  1  DRAM completion strobe, one cycle
- mem_rdata  in  mem_data_width  DRAM read line, valid with mem_ack

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE: mem_cs=0. The arbiter samples i_cs and d_cs. If only one is high, it enters that requester's GRANT state. If both are high, the winner follows the configured policy. If neither is high, it stays in IDLE.
- GRANT_x:
  - mem_cs=1.
  - mem_addr, mem_we, mem_wdata driven combinationally from requester x's live inputs.
  - The requester must hold its inputs stable while cs is high.
  - The arbiter stays in GRANT_x until mem_ack=1, then goes to RELEASE.
- Ack routing: x_ack = mem_ack while in GRANT_x. The other requester's ack is 0.
- Requester dropping cs during a grant is a protocol violation. The grant and mem_cs are held regardless until mem_ack, and the ack is still forwarded.
- RELEASE:
  - mem_cs=0 for exactly one cycle, then IDLE.
  - This guarantees DRAM sees cs low between transfers.
  - It gives the requester one cycle to drop cs so a completed request is never re-granted.
- i_rdata and d_rdata both equal mem_rdata at all times (broadcast). Only the ack qualifies the data.
- Outside any GRANT state: mem_addr=0, mem_we=0, mem_wdata=0.
- The other requester's pending cs is never lost; it is served in the next IDLE.

## Timing
- Reset values: state=IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, round-robin pointer=0 (I last served, so D wins the first tie).
- Grant latency: cs sampled high at edge n puts state GRANT_x after edge n, so mem_cs rises in cycle n+1 (one cycle after the request cycle).
- Ack: combinational pass-through, same cycle as mem_ack. The state leaves GRANT on that same edge.
- Turnaround: mem_ack edge → RELEASE for 1 cycle → IDLE for at least 1 cycle → next GRANT. Minimum gap between two mem_cs pulses is 2 cycles low.
- mem_ack in IDLE or RELEASE is ignored and not forwarded.
- rst asserted mid-transfer: immediately IDLE, mem_cs=0, acks=0, pointer=0. The DRAM is responsible for discarding the partial transfer.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: ties resolve against the last-granted requester.
  - A 1-bit pointer records the last-granted requester and updates on each grant.
  - Under sustained dual requests, grants strictly alternate I, D, I, D.
- Undefined: fixed priority, D-cache always wins ties. No pointer register exists.

## Test plan
- I read alone, in three steps:
  - i_cs=1, i_addr=0x0000_0400, i_we=0 → mem_cs=1 next cycle with mem_addr=0x400.
  - DRAM returns mem_ack and mem_rdata=0xA5…A5 → i_ack=1 the same cycle and i_rdata=0xA5…A5.
  - Then d_ack=0 and mem_cs=0 for 1 cycle.
- D write, in two steps:
  - d_cs=1, d_we=1, d_wdata=0x1234…, d_addr=0x0000_0820 → mem_we=1, mem_wdata=0x1234…, mem_addr=0x820.
  - After mem_ack → d_ack pulses for 1 cycle.
- Simultaneous i_cs=d_cs=1, both held:
  - Fixed priority: D is granted first, then I after the RELEASE/IDLE gap.
  - With `ARB_ROUND_ROBIN_EN`: the first grant is D, and 4 consecutive grants are D, I, D, I.
- Back-to-back same requester: d_cs is raised again one cycle after d_ack → mem_cs is low for 2 cycles between the pulses, and there is no double grant of the completed request.
- Stray mem_ack while in IDLE → i_ack=d_ack=0 and the state is unchanged.
- rst pulse during GRANT_I before mem_ack → mem_cs=0 asynchronously, with no ack. The still-high i_cs is re-granted 1 cycle after rst falls.

Source files
------------

// File: rtl/dram_port_if.sv
// dram_port_if: bundles the I-cache, D-cache and DRAM-facing signals that
// meet at the DRAM port arbiter. The arbiter uses the master modport; the
// caches and DRAM model together use the slave modport.
interface dram_port_if #(
  parameter int addr_width     = 32,
  parameter int mem_data_width = 256
) ();

  // I-cache request bundle
  logic [addr_width-1:0]     i_addr;
  logic                      i_cs;
  logic                      i_we;
  logic [mem_data_width-1:0] i_wdata;
  logic                      i_ack;
  logic [mem_data_width-1:0] i_rdata;

  // D-cache request bundle
  logic [addr_width-1:0]     d_addr;
  logic                      d_cs;
  logic                      d_we;
  logic [mem_data_width-1:0] d_wdata;
  logic                      d_ack;
  logic [mem_data_width-1:0] d_rdata;

  // Shared DRAM port
  logic [addr_width-1:0]     mem_addr;
  logic                      mem_cs;
  logic                      mem_we;
  logic [mem_data_width-1:0] mem_wdata;
  logic                      mem_ack;
  logic [mem_data_width-1:0] mem_rdata;

  modport master (
    input  i_addr, i_cs, i_we, i_wdata,
    output i_ack, i_rdata,
    input  d_addr, d_cs, d_we, d_wdata,
    output d_ack, d_rdata,
    output mem_addr, mem_cs, mem_we, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output i_addr, i_cs, i_we, i_wdata,
    input  i_ack, i_rdata,
    output d_addr, d_cs, d_we, d_wdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_cs, mem_we, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: grants the single DRAM port to either the I-cache or
// the D-cache, one line transfer at a time, and routes the DRAM ack back
// to the granted cache only. Every transfer is followed by a one-cycle
// RELEASE so DRAM always sees cs low between transfers and the finished
// requester has time to drop its cs before the arbiter samples again.
//
// Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// against the last-granted requester; otherwise the D-cache wins all ties.
module dram_port_arbiter (
  input  logic       clk,
  input  logic       rst,
  dram_port_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // High when the D-cache should win the grant decision taken in IDLE.
  logic pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 means the D-cache was granted most recently; reset to 0 so the
  // D-cache wins the first tie.
  logic last_d_q;

  assign pick_d = bus.d_cs && (!bus.i_cs || !last_d_q);

  // Remember which requester received the latest grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE && (bus.i_cs || bus.d_cs)) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = bus.d_cs;
`endif

  // State register; reset aborts any transfer in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision and DRAM-side / ack outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_ack     = 1'b0;
    bus.d_ack     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = GRANT_D;
        end else if (bus.i_cs) begin
          state_d = GRANT_I;
        end
      end

      GRANT_I: begin
        // The grant is held until mem_ack even if i_cs drops early.
        bus.mem_cs    = 1'b1;
        bus.mem_we    = bus.i_we;
        bus.mem_addr  = bus.i_addr;
        bus.mem_wdata = bus.i_wdata;
        bus.i_ack     = bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = RELEASE;
        end
      end

      GRANT_D: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_ack     = bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is broadcast; only the routed ack qualifies it.
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed scenarios followed by randomized traffic.
// Expected outputs come from a transfer-level model: who currently owns
// the DRAM port, how many sampling edges must pass before a new grant is
// allowed, and which requester was served last.
module tb_dram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst;

  dram_port_if #(.addr_width(AW), .mem_data_width(DW)) bus ();

  dram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = nobody, 1 = I-cache, 2 = D-cache.
  int owner   = 0;
  int cool    = 0;     // sampling edges still blocked after a completed transfer
  bit last_d  = 1'b0;  // D-cache was the last one granted
  bit i_done  = 1'b0;
  bit d_done  = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Advance the model by one rising edge, using the inputs seen at that edge.
  task automatic model_update();
    if (rst) begin
      owner = 0; cool = 0; last_d = 1'b0;
      return;
    end
    if (owner != 0) begin
      if (bus.mem_ack) begin
        if (owner == 1) i_done = 1'b1; else d_done = 1'b1;
        owner = 0;
        cool  = 1;
      end
    end else if (cool > 0) begin
      cool--;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.i_cs && bus.d_cs) owner = last_d ? 1 : 2;
      else if (bus.d_cs)        owner = 2;
      else if (bus.i_cs)        owner = 1;
`else
      if (bus.d_cs)      owner = 2;
      else if (bus.i_cs) owner = 1;
`endif
      if (owner != 0) last_d = (owner == 2);
    end
  endtask

  // Compare every output against the model, then advance one cycle.
  task automatic tick();
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wdata;
    #1;
    e_addr  = (owner == 1) ? bus.i_addr  : (owner == 2) ? bus.d_addr  : '0;
    e_we    = (owner == 1) ? bus.i_we    : (owner == 2) ? bus.d_we    : 1'b0;
    e_wdata = (owner == 1) ? bus.i_wdata : (owner == 2) ? bus.d_wdata : '0;
    check("mem_cs",    bus.mem_cs,    owner != 0);
    check("mem_addr",  bus.mem_addr,  e_addr);
    check("mem_we",    bus.mem_we,    e_we);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("i_ack",     bus.i_ack,     owner == 1 && bus.mem_ack);
    check("d_ack",     bus.d_ack,     owner == 2 && bus.mem_ack);
    check("i_rdata",   bus.i_rdata,   bus.mem_rdata);
    check("d_rdata",   bus.d_rdata,   bus.mem_rdata);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Wait (bounded) for the model to expect a grant, then confirm the DUT
  // forwards the expected requester.
  task automatic expect_grant(input string tag, input int who);
    int n = 0;
    while (owner == 0 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_granted"}, bus.mem_cs, 1'b1);
    check({tag, "_addr"}, bus.mem_addr, (who == 1) ? bus.i_addr : bus.d_addr);
  endtask

  task automatic ack_once(input logic [DW-1:0] data);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ack   = 1'b0;
  endtask

  // Hard stop if something hangs despite the bounded loops.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_grants;
    int low;
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_12;
    pat_a5 = {32{8'hA5}};
    pat_12 = {16{16'h1234}};

    bus.i_addr = '0; bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_wdata = '0;
    bus.d_addr = '0; bus.d_cs = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_cs",    bus.mem_cs,    1'b0);
    check("rst_mem_addr",  bus.mem_addr,  '0);
    check("rst_mem_we",    bus.mem_we,    1'b0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_i_ack",     bus.i_ack,     1'b0);
    check("rst_d_ack",     bus.d_ack,     1'b0);
    rst = 1'b0;
    owner = 0; cool = 0; last_d = 1'b0;
    tick();

    // I-cache read alone.
    bus.i_addr = 32'h0000_0400; bus.i_we = 1'b0; bus.i_cs = 1'b1;
    tick();
    #1;
    check("iread_cs",   bus.mem_cs,   1'b1);
    check("iread_addr", bus.mem_addr, 32'h400);
    check("iread_we",   bus.mem_we,   1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = pat_a5;
    #1;
    check("iread_ack",   bus.i_ack,   1'b1);
    check("iread_rdata", bus.i_rdata, pat_a5);
    check("iread_dack",  bus.d_ack,   1'b0);
    tick();
    bus.mem_ack = 1'b0; bus.i_cs = 1'b0;
    #1;
    check("iread_rel_cs", bus.mem_cs, 1'b0);
    check("iread_rel_dack", bus.d_ack, 1'b0);
    tick();
    tick();

    // D-cache write alone.
    bus.d_addr = 32'h0000_0820; bus.d_we = 1'b1; bus.d_wdata = pat_12; bus.d_cs = 1'b1;
    tick();
    #1;
    check("dwr_we",    bus.mem_we,    1'b1);
    check("dwr_wdata", bus.mem_wdata, pat_12);
    check("dwr_addr",  bus.mem_addr,  32'h820);
    bus.mem_ack = 1'b1;
    #1;
    check("dwr_ack", bus.d_ack, 1'b1);
    tick();
    bus.mem_ack = 1'b0; bus.d_cs = 1'b0;
    #1;
    check("dwr_ack_pulse", bus.d_ack, 1'b0);
    tick();
    tick();

    // Simultaneous requests held by both caches.
    bus.i_addr = 32'h0000_1000; bus.i_we = 1'b0;
    bus.d_addr = 32'h0000_2000; bus.d_we = 1'b0;
    bus.i_cs = 1'b1; bus.d_cs = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    n_grants = 4;
`else
    n_grants = 2;
`endif
    for (int k = 0; k < n_grants; k++) begin
      int who;
      who = (k % 2 == 0) ? 2 : 1;
      expect_grant($sformatf("tie%0d", k), who);
      ack_once(rand_line());
      if (who == 1) bus.i_cs = 1'b0; else bus.d_cs = 1'b0;
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      if (k < 2) begin
        if (who == 1) bus.i_cs = 1'b1; else bus.d_cs = 1'b1;
      end
`endif
    end
    bus.i_cs = 1'b0; bus.d_cs = 1'b0;
    tick();
    tick();

    // Back-to-back requests from the D-cache.
    bus.d_addr = 32'h0000_3000; bus.d_we = 1'b0; bus.d_cs = 1'b1;
    expect_grant("b2b_first", 2);
    ack_once(rand_line());
    bus.d_cs = 1'b0;
    low = 0;
    for (int n = 0; n < 6; n++) begin
      if (n == 1) bus.d_cs = 1'b1;
      #1;
      if (bus.mem_cs) break;
      low++;
      tick();
    end
    check("b2b_gap", low, 2);
    expect_grant("b2b_second", 2);
    ack_once(rand_line());
    bus.d_cs = 1'b0;
    tick();
    tick();

    // Stray ack while idle.
    bus.mem_ack = 1'b1;
    #1;
    check("stray_iack", bus.i_ack, 1'b0);
    check("stray_dack", bus.d_ack, 1'b0);
    tick();
    tick();
    bus.mem_ack = 1'b0;
    tick();

    // Reset in the middle of an I-cache grant.
    bus.i_addr = 32'h0000_5000; bus.i_we = 1'b0; bus.i_cs = 1'b1;
    expect_grant("rst_pre", 1);
    bus.mem_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_cs",   bus.mem_cs, 1'b0);
    check("rst_mid_iack", bus.i_ack,  1'b0);
    check("rst_mid_dack", bus.d_ack,  1'b0);
    owner = 0; cool = 0; last_d = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.mem_ack = 1'b0;
    tick();
    #1;
    check("rst_regrant_cs",   bus.mem_cs,   1'b1);
    check("rst_regrant_addr", bus.mem_addr, 32'h5000);
    ack_once(rand_line());
    bus.i_cs = 1'b0;
    tick();
    tick();

    // Randomized traffic from both caches plus stray DRAM acks.
    i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (i_done) begin
        bus.i_cs = 1'b0; i_done = 1'b0;
      end else if (!bus.i_cs && $urandom_range(2) == 0) begin
        bus.i_cs = 1'b1; bus.i_addr = $urandom; bus.i_we = 1'($urandom_range(1));
        bus.i_wdata = rand_line();
      end
      if (d_done) begin
        bus.d_cs = 1'b0; d_done = 1'b0;
      end else if (!bus.d_cs && $urandom_range(2) == 0) begin
        bus.d_cs = 1'b1; bus.d_addr = $urandom; bus.d_we = 1'($urandom_range(1));
        bus.d_wdata = rand_line();
      end
      bus.mem_ack   = (owner != 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      bus.mem_rdata = rand_line();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
